// File: rtl/dmac_arb_pkg.sv
// Shared types and helpers for the DMAC weighted round-robin arbiter.
// Holds the FSM state type and the rotate-priority pick function.
package dmac_arb_pkg;

  localparam int unsigned MAX_MASTER = 8;
  localparam int unsigned MAX_IDX_W  = $clog2(MAX_MASTER);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // Search starts just past last_owner and wraps modulo n.
  function automatic pick_t rr_pick(
    input logic [MAX_MASTER-1:0] valid,
    input logic [MAX_IDX_W-1:0]  last_owner,
    input int unsigned           n
  );
    pick_t                r;
    int unsigned          i;
    logic [MAX_IDX_W-1:0] j;
    r = '0;
    for (int unsigned k = 1; k <= MAX_MASTER; k++) begin
      i = (32'(last_owner) + k) % n;
      j = MAX_IDX_W'(i);
      if (!r.found && k <= n && valid[j]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dmac_rr_picker.sv
// Combinational rotate-priority encoder used while the arbiter is idle.
// Returns the first valid requester after last_owner, with wrap.
import dmac_arb_pkg::*;

module dmac_rr_picker #(
  parameter int N_MASTER = 4,
  localparam int IDX_W   = $clog2(N_MASTER)
) (
  input  logic [N_MASTER-1:0] valid,
  input  logic [IDX_W-1:0]    last_owner,
  output logic                found,
  output logic [IDX_W-1:0]    pick
);

  pick_t p;

  always_comb begin
    p = rr_pick(MAX_MASTER'(valid),
                MAX_IDX_W'(last_owner),
                N_MASTER);
  end

  assign found = p.found;
  assign pick  = IDX_W'(p.idx);

endmodule

// File: rtl/dmac_wrr_arbiter.sv
// Weighted round-robin, packet-locked arbiter for one DMAC AXI channel.
// Owner keeps the grant for up to weight packets; output is registered.
import dmac_arb_pkg::*;

module dmac_wrr_arbiter #(
  parameter int N_MASTER  = 4,
  parameter int DATA_SIZE = 32,
  parameter int WEIGHT_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTER*WEIGHT_W-1:0]  weight_i,
  input  logic [N_MASTER-1:0]           src_valid_i,
  input  logic [N_MASTER-1:0]           src_last_i,
  input  logic [N_MASTER*DATA_SIZE-1:0] src_data_i,
  output logic [N_MASTER-1:0]           src_ready_o,
  output logic                          dst_valid_o,
  output logic                          dst_last_o,
  output logic [DATA_SIZE-1:0]          dst_data_o,
  input  logic                          dst_ready_i,
  output logic [N_MASTER-1:0]           grant_o
);

  localparam int IDX_W = $clog2(N_MASTER);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(N_MASTER - 1);
  localparam logic [WEIGHT_W-1:0] ONE = WEIGHT_W'(1);

  state_e               state;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     last_owner;
  logic [IDX_W-1:0]     pick;
  logic [WEIGHT_W-1:0]  credit;
  logic [WEIGHT_W-1:0]  pick_w;
  logic                 pkt_open;
  logic                 found;
  logic                 can_load;
  logic                 hs;
  logic                 own_valid;
  logic                 own_last;
  logic [DATA_SIZE-1:0] own_data;

  dmac_rr_picker #(
    .N_MASTER(N_MASTER)
  ) u_picker (
    .valid     (src_valid_i),
    .last_owner(last_owner),
    .found     (found),
    .pick      (pick)
  );

  assign can_load  = !dst_valid_o || dst_ready_i;
  assign own_valid = src_valid_i[owner];
  assign own_last  = src_last_i[owner];
  assign own_data  =
    src_data_i[owner*DATA_SIZE +: DATA_SIZE];
  assign pick_w    =
    weight_i[pick*WEIGHT_W +: WEIGHT_W];
  assign hs = (state == BUSY) && own_valid && can_load;

  always_comb begin
    grant_o     = '0;
    src_ready_o = '0;
    if (state == BUSY) begin
      grant_o[owner]     = 1'b1;
      src_ready_o[owner] = can_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= LAST_IDX;
      credit      <= '0;
      pkt_open    <= 1'b0;
      dst_valid_o <= 1'b0;
      dst_last_o  <= 1'b0;
      dst_data_o  <= '0;
    end else begin
      if (hs) begin
        dst_valid_o <= 1'b1;
        dst_data_o  <= own_data;
        dst_last_o  <= own_last;
      end else if (dst_ready_i) begin
        dst_valid_o <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (found) begin
            owner    <= pick;
            credit   <= (pick_w == '0) ? ONE : pick_w;
            pkt_open <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (hs) begin
            if (own_last) begin
              pkt_open <= 1'b0;
              credit   <= credit - ONE;
              if (credit == ONE) begin
                state      <= IDLE;
                last_owner <= owner;
              end
            end else begin
              pkt_open <= 1'b1;
            end
          // an idle owner is released only between packets
          end else if (!own_valid && !pkt_open) begin
            state      <= IDLE;
            last_owner <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_wrr_arbiter.sv
// Scoreboard bench for dmac_wrr_arbiter: per-master beat queues feed
// the sources, expected output beats are checked by a monitor.
module tb_dmac_wrr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*WW-1:0] weight_i;
  logic [N-1:0]    src_valid_i;
  logic [N-1:0]    src_last_i;
  logic [N*DW-1:0] src_data_i;
  logic [N-1:0]    src_ready_o;
  logic            dst_valid_o;
  logic            dst_last_o;
  logic [DW-1:0]   dst_data_o;
  logic            dst_ready_i;
  logic [N-1:0]    grant_o;

  always #5 clk = ~clk;

  dmac_wrr_arbiter #(
    .N_MASTER (N),
    .DATA_SIZE(DW),
    .WEIGHT_W (WW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .weight_i   (weight_i),
    .src_valid_i(src_valid_i),
    .src_last_i (src_last_i),
    .src_data_i (src_data_i),
    .src_ready_o(src_ready_o),
    .dst_valid_o(dst_valid_o),
    .dst_last_o (dst_last_o),
    .dst_data_o (dst_data_o),
    .dst_ready_i(dst_ready_i),
    .grant_o    (grant_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          gap;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  beat_t srcq[N][$];
  int    wcnt[N];
  exp_t  expq[$];
  int    tests;
  int    fails;

  function automatic logic [31:0] mk(int m, int p, int b);
    return 32'(m * 256 + p * 16 + b);
  endfunction

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive();
    for (int m = 0; m < N; m++) begin
      if (srcq[m].size() > 0) begin
        src_valid_i[m]           = (wcnt[m] == 0);
        src_last_i[m]            = srcq[m][0].last;
        src_data_i[m*DW +: DW]   = srcq[m][0].data;
      end else begin
        src_valid_i[m]           = 1'b0;
        src_last_i[m]            = 1'b0;
        src_data_i[m*DW +: DW]   = '0;
      end
    end
  endtask

  task automatic push_beat(int m, logic [31:0] d,
                           logic l, int gap);
    beat_t b;
    b.data = d;
    b.last = l;
    b.gap  = gap;
    if (srcq[m].size() == 0) wcnt[m] = gap;
    srcq[m].push_back(b);
    drive();
  endtask

  task automatic push_exp(logic [31:0] d, logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    expq.push_back(e);
  endtask

  task automatic flush();
    for (int m = 0; m < N; m++) begin
      srcq[m].delete();
      wcnt[m] = 0;
    end
    expq.delete();
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({dst_valid_o, dst_last_o, dst_data_o,
               src_ready_o, grant_o}),
          64'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input bit lockchk);
    int  n;
    bit  busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
      if (lockchk && srcq[1].size() > 0 && !src_valid_i[1]) begin
        check("lock_grant", 64'(grant_o), 64'(4'b0010));
        check("lock_m3_ready", 64'(src_ready_o[3]), 64'(0));
      end
      busy = (expq.size() != 0);
      for (int m = 0; m < N; m++)
        if (srcq[m].size() != 0) busy = 1'b1;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got=%0d left exp=0", expq.size());
    end
    @(posedge clk);
    #2;
  endtask

  // Source driver: pop a beat after each observed handshake.
  initial begin : src_driver
    logic [N-1:0] hs;
    forever begin
      @(negedge clk);
      hs = src_valid_i & src_ready_o;
      @(posedge clk);
      #1;
      for (int m = 0; m < N; m++) begin
        if (hs[m] && !rst && srcq[m].size() > 0) begin
          void'(srcq[m].pop_front());
          if (srcq[m].size() > 0) wcnt[m] = srcq[m][0].gap;
        end else if (wcnt[m] > 0) begin
          wcnt[m]--;
        end
      end
      drive();
    end
  end

  // Monitor: compare each accepted output beat with the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ready_onehot",
              64'($countones(src_ready_o) <= 1), 64'(1));
        if (dst_valid_o && dst_ready_i) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat got=%h exp=none",
                     dst_data_o);
          end else begin
            e = expq.pop_front();
            check("beat", 64'({dst_last_o, dst_data_o}),
                  64'({e.last, e.data}));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] held;
    tests       = 0;
    fails       = 0;
    rst         = 1'b1;
    dst_ready_i = 1'b1;
    src_valid_i = '0;
    src_last_i  = '0;
    src_data_i  = '0;
    weight_i    = {4'd1, 4'd1, 4'd1, 4'd1};

    // single master m2, 4-beat packet
    do_reset();
    for (int b = 0; b < 4; b++) begin
      push_beat(2, 32'hA0 + 32'(b), b == 3, 0);
      push_exp(32'hA0 + 32'(b), b == 3);
    end
    @(negedge clk);
    check("t1_grant_c0", 64'(grant_o), 64'(0));
    @(negedge clk);
    check("t1_grant_c1", 64'(grant_o), 64'(4'b0100));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t1_valid_run", 64'(dst_valid_o), 64'(1));
    end
    @(negedge clk);
    check("t1_idle", 64'({dst_valid_o, grant_o}), 64'(0));
    wait_drain(1'b0);

    // equal weights, 1-beat packets
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int m = 0; m < N; m++) begin
        push_beat(m, mk(m, p, 0), 1'b1, 0);
        push_exp(mk(m, p, 0), 1'b1);
      end
    wait_drain(1'b0);

    // weighted: m0=3, m1=0 (acts as 1), m2=1, m3=1
    weight_i = {4'd1, 4'd1, 4'd0, 4'd3};
    do_reset();
    for (int m = 0; m < N; m++)
      for (int p = 0; p < ((m == 0) ? 6 : 2); p++)
        for (int b = 0; b < 2; b++)
          push_beat(m, mk(m, p, b), b == 1, 0);
    for (int r = 0; r < 2; r++) begin
      for (int p = 3 * r; p < 3 * r + 3; p++)
        for (int b = 0; b < 2; b++)
          push_exp(mk(0, p, b), b == 1);
      for (int m = 1; m < N; m++)
        for (int b = 0; b < 2; b++)
          push_exp(mk(m, r, b), b == 1);
    end
    wait_drain(1'b0);
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};

    // backpressure mid-packet
    do_reset();
    for (int b = 0; b < 4; b++) begin
      push_beat(1, mk(1, 0, b), b == 3, 0);
      push_exp(mk(1, 0, b), b == 3);
    end
    begin
      int n;
      n = 0;
      while (!(dst_valid_o && dst_data_o == mk(1, 0, 1))
             && n < 50) begin
        @(posedge clk);
        #2;
        n++;
      end
      check("bp_reach_beat1", 64'(dst_data_o), 64'(mk(1, 0, 1)));
    end
    dst_ready_i = 1'b0;
    held = dst_data_o;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold",
            64'({dst_valid_o, dst_last_o, dst_data_o, src_ready_o}),
            64'({1'b1, 1'b0, held, 4'b0000}));
    end
    @(posedge clk);
    #2;
    dst_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_release_rate", 64'(dst_valid_o), 64'(1));
    end
    wait_drain(1'b0);

    // packet lock: m1 stalls after its 2nd beat while m3 waits
    do_reset();
    for (int b = 0; b < 4; b++) begin
      push_beat(1, mk(1, 0, b), b == 3, (b == 2) ? 3 : 0);
      push_exp(mk(1, 0, b), b == 3);
    end
    push_beat(3, mk(3, 0, 0), 1'b1, 0);
    push_exp(mk(3, 0, 0), 1'b1);
    wait_drain(1'b1);

    // reset while a beat is held under backpressure
    do_reset();
    dst_ready_i = 1'b0;
    for (int b = 0; b < 3; b++)
      push_beat(1, mk(1, 1, b), b == 2, 0);
    begin
      int n;
      n = 0;
      while (!dst_valid_o && n < 50) begin
        @(posedge clk);
        #2;
        n++;
      end
      check("rst_mid_valid", 64'(dst_valid_o), 64'(1));
    end
    rst = 1'b1;
    flush();
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outputs",
          64'({dst_valid_o, dst_last_o, dst_data_o,
               src_ready_o, grant_o}),
          64'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    dst_ready_i = 1'b1;
    push_beat(2, mk(2, 2, 0), 1'b1, 0);
    push_beat(0, mk(0, 2, 0), 1'b1, 0);
    push_exp(mk(0, 2, 0), 1'b1);
    push_exp(mk(2, 2, 0), 1'b1);
    @(negedge clk);
    check("rst_after_idle", 64'(grant_o), 64'(0));
    @(negedge clk);
    check("rst_after_m0_first", 64'(grant_o), 64'(4'b0001));
    wait_drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
